// File: rtl/idelayctrl_reset_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// idelayctrl_pkg
// Shared types and helpers for the IDELAYCTRL reset sequencer.
//   seq_state_t   : sequencer FSM state (PULSE, WAIT_READY, LOCKED)
//   counter_width : width of the shared pulse/timeout counter
// ----------------------------------------------------------------------------
package idelayctrl_pkg;

    typedef enum logic [1:0] {
        PULSE      = 2'd0,
        WAIT_READY = 2'd1,
        LOCKED     = 2'd2
    } seq_state_t;

    // The same counter times the reset pulse and the ready timeout, so it
    // must be wide enough to hold the larger of the two terminal counts.
    function automatic int counter_width(input int reset_cycles, input int timeout_cycles);
        int largest;
        largest = (reset_cycles > timeout_cycles) ? reset_cycles : timeout_cycles;
        return $clog2(largest + 1);
    endfunction

endpackage

// File: rtl/idelayctrl_reset_sequencer_if.sv
// ----------------------------------------------------------------------------
// idelayctrl_reset_sequencer_if
// Bundles the sequencer's control, IDELAYCTRL and status signals.
//   recalibrate       : 1-cycle request to restart calibration
//   clear_errors      : clears timeout_error and retry_count
//   idelayctrl_reset  : to IDELAYCTRL RST (active high)
//   idelayctrl_ready  : from IDELAYCTRL RDY (asynchronous)
//   calibrated        : high while locked
//   calibration_lost  : 1-cycle pulse when ready drops while locked
//   timeout_pulse     : 1-cycle pulse when a wait for ready times out
//   timeout_error     : sticky timeout flag
//   retry_count       : saturating count of timeout/loss restarts
// Modports: master = the sequencer, slave = the surrounding logic.
// ----------------------------------------------------------------------------
interface idelayctrl_reset_sequencer_if #(
    parameter int RETRY_WIDTH = 8
);
    logic                   recalibrate;
    logic                   clear_errors;
    logic                   idelayctrl_reset;
    logic                   idelayctrl_ready;
    logic                   calibrated;
    logic                   calibration_lost;
    logic                   timeout_pulse;
    logic                   timeout_error;
    logic [RETRY_WIDTH-1:0] retry_count;

    modport master (
        input  recalibrate,
        input  clear_errors,
        input  idelayctrl_ready,
        output idelayctrl_reset,
        output calibrated,
        output calibration_lost,
        output timeout_pulse,
        output timeout_error,
        output retry_count
    );

    modport slave (
        output recalibrate,
        output clear_errors,
        output idelayctrl_ready,
        input  idelayctrl_reset,
        input  calibrated,
        input  calibration_lost,
        input  timeout_pulse,
        input  timeout_error,
        input  retry_count
    );

endinterface

// File: rtl/idelayctrl_reset_sequencer_sync.sv
// ----------------------------------------------------------------------------
// cdc_bit_synchronizer
// Multi-flop synchroniser bringing one asynchronous bit into the clock domain.
//   clock    : destination clock
//   reset_n  : asynchronous active-low reset, clears every stage
//   async_in : asynchronous input bit
//   sync_out : synchronised output, STAGES flops behind async_in
// ----------------------------------------------------------------------------
module cdc_bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_ff;

    // Shift the input through the chain; the first flop may go metastable,
    // the later ones give it time to settle before anyone uses the value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_ff[STAGES-1];

endmodule

// File: rtl/idelayctrl_reset_sequencer.sv
// ----------------------------------------------------------------------------
// idelayctrl_reset_sequencer
// Drives one IDELAYCTRL reset, waits for ready, and reports a clean
// calibrated level plus timeout/loss events.
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : idelayctrl_reset_sequencer_if.master (control, IDELAYCTRL,
//              status signals)
// ----------------------------------------------------------------------------
module idelayctrl_reset_sequencer
    import idelayctrl_pkg::*;
#(
    parameter int RESET_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int SYNC_STAGES    = 2,
    parameter int RETRY_WIDTH    = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    idelayctrl_reset_sequencer_if.master  bus
);

    localparam int CW = counter_width(RESET_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    // A stale ready must drain from the synchroniser before WAIT_READY looks.
    if (RESET_CYCLES < SYNC_STAGES + 2) begin : g_bad_reset_cycles
        $error("RESET_CYCLES must be >= SYNC_STAGES+2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
        $error("TIMEOUT_CYCLES must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("SYNC_STAGES must be >= 2");
    end

    seq_state_t             state;
    logic [CW-1:0]          count;
    logic                   ready_sync;
    logic                   reset_q;
    logic                   calibrated_q;
    logic                   lost_q;
    logic                   timeout_q;
    logic                   error_q;
    logic [RETRY_WIDTH-1:0] retry_q;

    cdc_bit_synchronizer #(
        .STAGES   (SYNC_STAGES)
    ) u_ready_sync (
        .clock    (clock),
        .reset_n  (reset_n),
        .async_in (bus.idelayctrl_ready),
        .sync_out (ready_sync)
    );

    // A restart caused by timeout or loss bumps the count; if clear_errors
    // lands in the same cycle the event still counts, leaving exactly one.
    function automatic logic [RETRY_WIDTH-1:0] bump_retry(
        input logic [RETRY_WIDTH-1:0] current,
        input logic                   clear
    );
        if (clear) begin
            return RETRY_WIDTH'(1);
        end
        if (&current) begin
            return current;
        end
        return current + 1'b1;
    endfunction

    // Sequencer FSM with its shared counter and all registered outputs.
    // clear_errors is applied first so a simultaneous timeout or loss,
    // assigned later in the block, overrides it. recalibrate outranks every
    // state transition and silently restarts the pulse without counting.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= PULSE;
            count        <= '0;
            reset_q      <= 1'b1;
            calibrated_q <= 1'b0;
            lost_q       <= 1'b0;
            timeout_q    <= 1'b0;
            error_q      <= 1'b0;
            retry_q      <= '0;
        end else begin
            lost_q    <= 1'b0;
            timeout_q <= 1'b0;

            if (bus.clear_errors) begin
                error_q <= 1'b0;
                retry_q <= '0;
            end

            if (bus.recalibrate) begin
                state        <= PULSE;
                count        <= '0;
                reset_q      <= 1'b1;
                calibrated_q <= 1'b0;
            end else begin
                case (state)
                    PULSE: begin
                        if (count == RESET_LAST) begin
                            state   <= WAIT_READY;
                            count   <= '0;
                            reset_q <= 1'b0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    WAIT_READY: begin
                        if (ready_sync) begin
                            state        <= LOCKED;
                            count        <= '0;
                            calibrated_q <= 1'b1;
                        end else if (count == TIMEOUT_LAST) begin
                            state     <= PULSE;
                            count     <= '0;
                            reset_q   <= 1'b1;
                            timeout_q <= 1'b1;
                            error_q   <= 1'b1;
                            retry_q   <= bump_retry(retry_q, bus.clear_errors);
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (!ready_sync) begin
                            state        <= PULSE;
                            count        <= '0;
                            reset_q      <= 1'b1;
                            calibrated_q <= 1'b0;
                            lost_q       <= 1'b1;
                            retry_q      <= bump_retry(retry_q, bus.clear_errors);
                        end
                    end
                    default: begin
                        state        <= PULSE;
                        count        <= '0;
                        reset_q      <= 1'b1;
                        calibrated_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.idelayctrl_reset = reset_q;
    assign bus.calibrated       = calibrated_q;
    assign bus.calibration_lost = lost_q;
    assign bus.timeout_pulse    = timeout_q;
    assign bus.timeout_error    = error_q;
    assign bus.retry_count      = retry_q;

endmodule

// File: tb/tb_idelayctrl_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_idelayctrl_reset_sequencer
// Directed bench for idelayctrl_reset_sequencer with RESET_CYCLES=16,
// TIMEOUT_CYCLES=64, SYNC_STAGES=2, RETRY_WIDTH=2. Outputs are sampled 1 ns
// after each rising edge; inputs are driven at the same point.
// ----------------------------------------------------------------------------
module tb_idelayctrl_reset_sequencer;

    localparam int RESET_CYCLES   = 16;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int SYNC_STAGES    = 2;
    localparam int RETRY_WIDTH    = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    idelayctrl_reset_sequencer_if #(.RETRY_WIDTH(RETRY_WIDTH)) bus ();

    idelayctrl_reset_sequencer #(
        .RESET_CYCLES   (RESET_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES),
        .RETRY_WIDTH    (RETRY_WIDTH)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // 10 ns clock.
    always #5 clock = ~clock;

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Count consecutive samples with idelayctrl_reset high, starting with the
    // current one; also count event pulses seen after the first sample.
    task automatic measure_reset(output int width, output int lost_after, output int tout_after);
        width = 0;
        lost_after = 0;
        tout_after = 0;
        while (bus.idelayctrl_reset === 1'b1 && width < 200) begin
            width++;
            step();
            if (bus.calibration_lost === 1'b1) lost_after++;
            if (bus.timeout_pulse === 1'b1) tout_after++;
        end
    endtask

    task automatic wait_calibrated(output int cycles);
        cycles = 0;
        while (bus.calibrated !== 1'b1 && cycles < 200) begin
            step();
            cycles++;
        end
    endtask

    task automatic wait_lost(output int cycles);
        cycles = 0;
        while (bus.calibration_lost !== 1'b1 && cycles < 200) begin
            step();
            cycles++;
        end
    endtask

    task automatic wait_timeout(output int cycles);
        cycles = 0;
        while (bus.timeout_pulse !== 1'b1 && cycles < 200) begin
            step();
            cycles++;
        end
    endtask

    task automatic pulse_recalibrate();
        bus.recalibrate = 1'b1;
        step();
        bus.recalibrate = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) step();
        checks++; if (bus.idelayctrl_reset !== 1'b1) begin failures++; $display("[TB] FAIL reset_rst got=%0b want=1", bus.idelayctrl_reset); end
        checks++; if (bus.calibrated !== 1'b0) begin failures++; $display("[TB] FAIL reset_cal got=%0b want=0", bus.calibrated); end
        checks++; if (bus.calibration_lost !== 1'b0) begin failures++; $display("[TB] FAIL reset_lost got=%0b want=0", bus.calibration_lost); end
        checks++; if (bus.timeout_pulse !== 1'b0) begin failures++; $display("[TB] FAIL reset_tpulse got=%0b want=0", bus.timeout_pulse); end
        checks++; if (bus.timeout_error !== 1'b0) begin failures++; $display("[TB] FAIL reset_terr got=%0b want=0", bus.timeout_error); end
        checks++; if (bus.retry_count !== 2'd0) begin failures++; $display("[TB] FAIL reset_retry got=%0d want=0", bus.retry_count); end
    endtask

    task automatic test_power_up();
        int w, l, t, c;
        @(posedge clock);
        #1 reset_n = 1'b1;
        measure_reset(w, l, t);
        checks++; if (w != 16) begin failures++; $display("[TB] FAIL pwr_pulse_width got=%0d want=16", w); end
        repeat (14) step();
        bus.idelayctrl_ready = 1'b1;
        wait_calibrated(c);
        checks++; if (c != 3) begin failures++; $display("[TB] FAIL pwr_lock_latency got=%0d want=3", c); end
        checks++; if (bus.retry_count !== 2'd0) begin failures++; $display("[TB] FAIL pwr_retry got=%0d want=0", bus.retry_count); end
        checks++; if (bus.timeout_error !== 1'b0) begin failures++; $display("[TB] FAIL pwr_terr got=%0b want=0", bus.timeout_error); end
    endtask

    task automatic test_loss();
        int w, l, t, c;
        step();
        bus.idelayctrl_ready = 1'b0;
        wait_lost(c);
        checks++; if (c != 3) begin failures++; $display("[TB] FAIL loss_latency got=%0d want=3", c); end
        checks++; if (bus.calibrated !== 1'b0) begin failures++; $display("[TB] FAIL loss_cal got=%0b want=0", bus.calibrated); end
        checks++; if (bus.retry_count !== 2'd1) begin failures++; $display("[TB] FAIL loss_retry got=%0d want=1", bus.retry_count); end
        bus.idelayctrl_ready = 1'b1;
        measure_reset(w, l, t);
        checks++; if (w != 16) begin failures++; $display("[TB] FAIL loss_pulse_width got=%0d want=16", w); end
        checks++; if (l != 0) begin failures++; $display("[TB] FAIL loss_pulse_once got=%0d want=0", l); end
        wait_calibrated(c);
        checks++; if (c != 1) begin failures++; $display("[TB] FAIL loss_relock got=%0d want=1", c); end
        checks++; if (bus.retry_count !== 2'd1) begin failures++; $display("[TB] FAIL loss_retry_after got=%0d want=1", bus.retry_count); end
    endtask

    task automatic test_recalibrate();
        int w, l, t, c;
        step();
        pulse_recalibrate();
        checks++; if (bus.calibrated !== 1'b0) begin failures++; $display("[TB] FAIL recal_cal got=%0b want=0", bus.calibrated); end
        checks++; if (bus.idelayctrl_reset !== 1'b1) begin failures++; $display("[TB] FAIL recal_rst got=%0b want=1", bus.idelayctrl_reset); end
        checks++; if (bus.calibration_lost !== 1'b0) begin failures++; $display("[TB] FAIL recal_lost got=%0b want=0", bus.calibration_lost); end
        repeat (5) step();
        pulse_recalibrate();
        measure_reset(w, l, t);
        checks++; if (w != 16) begin failures++; $display("[TB] FAIL recal_pulse_width got=%0d want=16", w); end
        checks++; if (l != 0) begin failures++; $display("[TB] FAIL recal_no_lost got=%0d want=0", l); end
        checks++; if (bus.retry_count !== 2'd1) begin failures++; $display("[TB] FAIL recal_retry got=%0d want=1", bus.retry_count); end
        wait_calibrated(c);
        checks++; if (c != 1) begin failures++; $display("[TB] FAIL recal_relock got=%0d want=1", c); end
    endtask

    task automatic test_timeout();
        int w, l, t, c;
        bus.idelayctrl_ready = 1'b0;
        bus.recalibrate      = 1'b1;
        bus.clear_errors     = 1'b1;
        step();
        bus.recalibrate  = 1'b0;
        bus.clear_errors = 1'b0;
        checks++; if (bus.retry_count !== 2'd0) begin failures++; $display("[TB] FAIL to_clear_retry got=%0d want=0", bus.retry_count); end
        checks++; if (bus.calibration_lost !== 1'b0) begin failures++; $display("[TB] FAIL to_recal_lost got=%0b want=0", bus.calibration_lost); end
        measure_reset(w, l, t);
        checks++; if (w != 16) begin failures++; $display("[TB] FAIL to_pulse_width got=%0d want=16", w); end
        wait_timeout(c);
        checks++; if (c != 64) begin failures++; $display("[TB] FAIL to_latency got=%0d want=64", c); end
        checks++; if (bus.timeout_error !== 1'b1) begin failures++; $display("[TB] FAIL to_terr got=%0b want=1", bus.timeout_error); end
        checks++; if (bus.retry_count !== 2'd1) begin failures++; $display("[TB] FAIL to_retry got=%0d want=1", bus.retry_count); end
        measure_reset(w, l, t);
        checks++; if (w != 16) begin failures++; $display("[TB] FAIL to_repulse_width got=%0d want=16", w); end
        checks++; if (t != 0) begin failures++; $display("[TB] FAIL to_pulse_once got=%0d want=0", t); end
    endtask

    task automatic test_saturation();
        int w, l, t, c;
        wait_timeout(c);
        checks++; if (bus.retry_count !== 2'd2) begin failures++; $display("[TB] FAIL sat_retry2 got=%0d want=2", bus.retry_count); end
        measure_reset(w, l, t);
        wait_timeout(c);
        checks++; if (bus.retry_count !== 2'd3) begin failures++; $display("[TB] FAIL sat_retry3 got=%0d want=3", bus.retry_count); end
        measure_reset(w, l, t);
        wait_timeout(c);
        checks++; if (c != 64) begin failures++; $display("[TB] FAIL sat_latency got=%0d want=64", c); end
        checks++; if (bus.retry_count !== 2'd3) begin failures++; $display("[TB] FAIL sat_hold got=%0d want=3", bus.retry_count); end
        repeat (79) step();
        bus.clear_errors = 1'b1;
        step();
        bus.clear_errors = 1'b0;
        checks++; if (bus.timeout_pulse !== 1'b1) begin failures++; $display("[TB] FAIL sat_clr_tpulse got=%0b want=1", bus.timeout_pulse); end
        checks++; if (bus.timeout_error !== 1'b1) begin failures++; $display("[TB] FAIL sat_clr_terr got=%0b want=1", bus.timeout_error); end
        checks++; if (bus.retry_count !== 2'd1) begin failures++; $display("[TB] FAIL sat_clr_retry got=%0d want=1", bus.retry_count); end
    endtask

    task automatic test_async_reset();
        int w, l, t, c;
        measure_reset(w, l, t);
        repeat (3) step();
        checks++; if (bus.idelayctrl_reset !== 1'b0) begin failures++; $display("[TB] FAIL ar_wait_pre got=%0b want=0", bus.idelayctrl_reset); end
        #3 reset_n = 1'b0;
        #1;
        checks++; if (bus.idelayctrl_reset !== 1'b1) begin failures++; $display("[TB] FAIL ar_wait_rst got=%0b want=1", bus.idelayctrl_reset); end
        checks++; if (bus.timeout_error !== 1'b0) begin failures++; $display("[TB] FAIL ar_wait_terr got=%0b want=0", bus.timeout_error); end
        checks++; if (bus.retry_count !== 2'd0) begin failures++; $display("[TB] FAIL ar_wait_retry got=%0d want=0", bus.retry_count); end
        bus.idelayctrl_ready = 1'b1;
        step();
        reset_n = 1'b1;
        measure_reset(w, l, t);
        checks++; if (w != 16) begin failures++; $display("[TB] FAIL ar_repulse_width got=%0d want=16", w); end
        wait_calibrated(c);
        checks++; if (c != 1) begin failures++; $display("[TB] FAIL ar_lock got=%0d want=1", c); end
        step();
        #3 reset_n = 1'b0;
        #1;
        checks++; if (bus.calibrated !== 1'b0) begin failures++; $display("[TB] FAIL ar_lock_cal got=%0b want=0", bus.calibrated); end
        checks++; if (bus.idelayctrl_reset !== 1'b1) begin failures++; $display("[TB] FAIL ar_lock_rst got=%0b want=1", bus.idelayctrl_reset); end
        checks++; if (bus.calibration_lost !== 1'b0) begin failures++; $display("[TB] FAIL ar_lock_lost got=%0b want=0", bus.calibration_lost); end
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        bus.recalibrate      = 1'b0;
        bus.clear_errors     = 1'b0;
        bus.idelayctrl_ready = 1'b0;
        test_reset();
        test_power_up();
        test_loss();
        test_recalibrate();
        test_timeout();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
